evm_poll_ctrl: RTL and testbench
================================

Name: evm_poll_ctrl

Overview:
- Parametrised successor to the team's 4-candidate, 3-bit voting counter. Adds:
  - a configurable candidate count and counter width;
  - on-chip vote-button synchronisation and debounce, so no slow divided clock is used;
  - a poll session FSM (IDLE/OPEN/CLOSED);
  - saturating counters, a total-vote counter, and registered leader/tie results.
- Sits between board buttons/switches and the display/LED driver, all on the single system clock.

Parameters:
- N_CAND, 4, number of candidates (2..16).
- CNT_W, 8, width of each per-candidate counter and of total_votes.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles vote_btn must be stable before the filtered level changes (>=2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- open_poll  in  1  synchronous pulse/level; opens a new poll.
- close_poll  in  1  synchronous pulse/level; closes the poll.
- cand_sel  in  IDX_W  selected candidate, IDX_W = max(1,$clog2(N_CAND)).
- vote_btn  in  1  raw asynchronous push button, active high.
- vote_counts  out  N_CAND*CNT_W  packed counts; candidate i occupies [i*CNT_W +: CNT_W].
- total_votes  out  CNT_W  accepted votes this poll.
- leader  out  IDX_W  index of the leading candidate.
- tie  out  1  more than one candidate shares the maximum count.
- result_valid  out  1  high only in CLOSED.
- vote_ack  out  1  one-cycle pulse, vote counted.
- vote_rej  out  1  one-cycle pulse, vote event refused.
- state  out  2  00 IDLE, 01 OPEN, 10 CLOSED.

Behaviour:
- Reset values (asynchronous): state=IDLE; all counts, total_votes, leader, tie, result_valid, vote_ack and vote_rej = 0; synchroniser and debounce state = 0.
- vote_btn path:
  - 2-flop synchroniser, then debounce counter.
  - The filtered level flips once the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
- Vote event: a 0->1 transition of the filtered level, i.e. one event per press. Holding the button never produces a second event.
- FSM transitions:
  - IDLE: open_poll -> OPEN, all counts cleared in the same clock edge.
  - OPEN: close_poll -> CLOSED. open_poll is ignored (no mid-poll clear). close_poll has priority over open_poll.
  - CLOSED: open_poll -> OPEN with counts cleared; otherwise hold.
- Vote event handling in OPEN, with close_poll low that cycle:
  - cand_sel < N_CAND and the selected count < 2^CNT_W-1: increment that count and total_votes on the next edge; vote_ack pulses in the same cycle the count updates.
  - cand_sel >= N_CAND: vote_rej pulses, nothing counted.
  - Selected count saturated: count unchanged, vote_rej pulses. total_votes also saturates independently.
- Vote event in IDLE, in CLOSED, or in the cycle close_poll is sampled in OPEN: vote_rej pulses, nothing counted.
- vote_ack and vote_rej are never both high.
- Leader/tie:
  - Recomputed every cycle from the counts and registered, so they lag a count change by 1 cycle.
  - leader = lowest index among candidates holding the maximum. All zeros -> leader=0, tie=1 (N_CAND>=2).
- result_valid rises on the edge entering CLOSED; leader/tie are final one cycle after that edge, since counts are frozen.
- cand_sel is sampled in the cycle the vote event is detected; changes at other times have no effect.
- Reset mid-poll aborts the poll: counts are lost and state returns to IDLE. A button held through reset release produces no event until it is released and pressed again.

Decomposition:
- evm_pkg holds:
  - state encoding constants (ST_IDLE, ST_OPEN, ST_CLOSED);
  - the IDX_W helper function;
  - the packed-count slice helper.
- One sub-module: evm_debounce (synchroniser + stability counter + rising-edge pulse), parameter DEBOUNCE_CYCLES, ports clk, reset, din, level, rise.
- The max/tie search is a loop inside evm_poll_ctrl, not a separate module.

Test Plan (N_CAND=4, CNT_W=3, DEBOUNCE_CYCLES=4 unless noted):
- Reset, open_poll, then 3 clean presses on cand_sel=2 -> vote_counts = {0,3,0,0}, total_votes=3, three vote_ack pulses, leader=2, tie=0.
- Press with 2-cycle bounce glitches (pulses shorter than 4 cycles) before a 10-cycle hold -> exactly one vote_ack; a 50-cycle hold still gives one count.
- 9 presses on cand 0 -> count0 saturates at 7; presses 8 and 9 give vote_rej, total_votes=7.
- Votes 2 on cand 1 and 2 on cand 3, then close_poll -> state=CLOSED, result_valid=1, leader=1, tie=1. A further press -> vote_rej, counts unchanged.
- N_CAND=3, press with cand_sel=3 -> vote_rej, counts unchanged. Press in IDLE -> vote_rej.
- Mid-poll with counts nonzero: assert reset asynchronously (off clock edge) -> all outputs 0 immediately, state=IDLE. Then CLOSED followed by open_poll -> counts cleared, state=OPEN.

Source files
------------

// File: rtl/evm_pkg.sv
// Shared definitions for the poll controller: state encoding, index width
// and packed-count slice helpers.
package evm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_OPEN   = 2'b01,
    ST_CLOSED = 2'b10
  } evm_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/evm_poll_ctrl_if.sv
// Button/switch inputs and display-side results of the poll controller.
interface evm_poll_ctrl_if #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8
);
  localparam int IDX_W = evm_pkg::idx_w(N_CAND);

  logic                    open_poll;
  logic                    close_poll;
  logic [IDX_W-1:0]        cand_sel;
  logic                    vote_btn;
  logic [N_CAND*CNT_W-1:0] vote_counts;
  logic [CNT_W-1:0]        total_votes;
  logic [IDX_W-1:0]        leader;
  logic                    tie;
  logic                    result_valid;
  logic                    vote_ack;
  logic                    vote_rej;
  logic [1:0]              state;

  modport master (
    output open_poll, close_poll, cand_sel, vote_btn,
    input  vote_counts, total_votes, leader, tie, result_valid,
           vote_ack, vote_rej, state
  );

  modport slave (
    input  open_poll, close_poll, cand_sel, vote_btn,
    output vote_counts, total_votes, leader, tie, result_valid,
           vote_ack, vote_rej, state
  );
endinterface

// File: rtl/evm_debounce.sv
// Two-flop synchroniser and stability counter for a raw push button; rise
// pulses once per debounced press.
module evm_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0, sync_p1;
  logic [CW-1:0] stab_cnt;
  logic [1:0]    fill;
  logic          armed;
  logic          hit;

  assign hit = (sync_p1 != level) && (stab_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // armed only after a released button has been seen through a filled
  // synchroniser, so a button held across reset never produces an event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      stab_cnt <= '0;
      fill     <= '0;
      armed    <= 1'b0;
      level    <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      fill    <= {fill[0], 1'b1};
      if (fill[1] && !sync_p1)
        armed <= 1'b1;
      if (sync_p1 != level) begin
        if (hit) begin
          level    <= sync_p1;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + CW'(1);
        end
      end else begin
        stab_cnt <= '0;
      end
      rise <= hit && sync_p1 && armed;
    end
  end

endmodule

// File: rtl/evm_poll_ctrl.sv
// Poll session controller: debounced vote button, IDLE/OPEN/CLOSED session,
// saturating per-candidate and total counters, registered leader/tie.
module evm_poll_ctrl
  import evm_pkg::*;
#(
  parameter int N_CAND          = 4,
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic            clk,
  input logic            reset,
  evm_poll_ctrl_if.slave bus
);
  localparam int               IDX_W   = idx_w(N_CAND);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  evm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_CAND];
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] sel_cnt;
  logic             sel_ok;
  logic             btn_level, btn_rise, vote_evt;
  logic             clear, inc, ack_d, rej_d;
  logic             ack_q, rej_q;
  logic [CNT_W-1:0] max_p0;
  logic [IDX_W-1:0] lead_p0, leader_p1;
  logic             tie_p0, tie_p1;
  int               n_max;

  evm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (bus.vote_btn),
    .level (btn_level),
    .rise  (btn_rise)
  );

  assign vote_evt = btn_rise & btn_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    inc     = 1'b0;
    ack_d   = 1'b0;
    rej_d   = 1'b0;
    sel_cnt = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < N_CAND; i++) begin
      if (int'(bus.cand_sel) == i) begin
        sel_cnt = cnt_q[i];
        sel_ok  = 1'b1;
      end
    end
    unique case (state_q)
      ST_IDLE: if (bus.open_poll) begin
        state_d = ST_OPEN;
        clear   = 1'b1;
      end
      ST_OPEN: if (bus.close_poll) state_d = ST_CLOSED;
      ST_CLOSED: if (bus.open_poll) begin
        state_d = ST_OPEN;
        clear   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // close_poll wins over a vote arriving in the same cycle
    if (vote_evt) begin
      if (state_q == ST_OPEN && !bus.close_poll && sel_ok && sel_cnt != CNT_MAX) begin
        inc   = 1'b1;
        ack_d = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
      total_q <= '0;
      ack_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      ack_q <= ack_d;
      rej_q <= rej_d;
      if (clear) begin
        for (int i = 0; i < N_CAND; i++) cnt_q[i] <= '0;
        total_q <= '0;
      end else if (inc) begin
        for (int i = 0; i < N_CAND; i++)
          if (int'(bus.cand_sel) == i) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        if (total_q != CNT_MAX) total_q <= total_q + CNT_W'(1);
      end
    end
  end

  // stage p0: max search over live counts (lowest index wins ties)
  always_comb begin
    max_p0  = cnt_q[0];
    lead_p0 = '0;
    n_max   = 0;
    for (int i = 1; i < N_CAND; i++) begin
      if (cnt_q[i] > max_p0) begin
        max_p0  = cnt_q[i];
        lead_p0 = IDX_W'(i);
      end
    end
    for (int i = 0; i < N_CAND; i++)
      if (cnt_q[i] == max_p0) n_max++;
    tie_p0 = (n_max > 1);
  end

  // stage p1: registered leader/tie, one cycle behind the counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leader_p1 <= '0;
      tie_p1    <= 1'b0;
    end else begin
      leader_p1 <= lead_p0;
      tie_p1    <= tie_p0;
    end
  end

  for (genvar g = 0; g < N_CAND; g++) begin : g_pack
    localparam int LSB = cnt_lsb(g, CNT_W);
    assign bus.vote_counts[LSB +: CNT_W] = cnt_q[g];
  end

  assign bus.total_votes  = total_q;
  assign bus.leader       = leader_p1;
  assign bus.tie          = tie_p1;
  assign bus.result_valid = (state_q == ST_CLOSED);
  assign bus.vote_ack     = ack_q;
  assign bus.vote_rej     = rej_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_evm_poll_ctrl.sv
// Directed bench for evm_poll_ctrl: a 4-candidate and a 3-candidate instance,
// 3-bit counters, 4-cycle debounce.
module tb_evm_poll_ctrl;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, failures = 0;
  int ack4 = 0, rej4 = 0, ack3 = 0, rej3 = 0, both = 0;
  int a0, r0, lat;

  evm_poll_ctrl_if #(.N_CAND(4), .CNT_W(3)) b4 ();
  evm_poll_ctrl_if #(.N_CAND(3), .CNT_W(3)) b3 ();

  evm_poll_ctrl #(.N_CAND(4), .CNT_W(3), .DEBOUNCE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .bus(b4));
  evm_poll_ctrl #(.N_CAND(3), .CNT_W(3), .DEBOUNCE_CYCLES(4)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b4.vote_ack) ack4++;
    if (b4.vote_rej) rej4++;
    if (b3.vote_ack) ack3++;
    if (b3.vote_rej) rej3++;
    if ((b4.vote_ack && b4.vote_rej) || (b3.vote_ack && b3.vote_rej)) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic drive_btn(input bit on3, input logic v);
    if (on3) b3.vote_btn = v;
    else     b4.vote_btn = v;
  endtask

  task automatic press(input bit on3, input int hold);
    @(negedge clk); drive_btn(on3, 1'b1);
    repeat (hold) @(negedge clk);
    drive_btn(on3, 1'b0);
    repeat (12) @(negedge clk);
  endtask

  task automatic pulse4(input bit is_open);
    @(negedge clk);
    if (is_open) b4.open_poll = 1'b1; else b4.close_poll = 1'b1;
    @(negedge clk);
    b4.open_poll = 1'b0; b4.close_poll = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    b4.open_poll = 0; b4.close_poll = 0; b4.cand_sel = '0; b4.vote_btn = 0;
    b3.open_poll = 0; b3.close_poll = 0; b3.cand_sel = '0; b3.vote_btn = 0;
    repeat (2) @(negedge clk);
    chk("rst_state",  32'(b4.state), 0);
    chk("rst_counts", 32'(b4.vote_counts), 0);
    chk("rst_total",  32'(b4.total_votes), 0);
    chk("rst_leader", 32'(b4.leader), 0);
    chk("rst_tie",    32'(b4.tie), 0);
    chk("rst_rv",     32'(b4.result_valid), 0);
    chk("rst_ackrej", 32'({b4.vote_ack, b4.vote_rej}), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_tie", 32'(b4.tie), 1);

    // three-candidate instance: IDLE press, out-of-range candidate, valid vote
    press(1, 10);
    chk("idle_rej3", 32'(rej3), 1);
    chk("idle_ack3", 32'(ack3), 0);
    @(negedge clk); b3.open_poll = 1'b1; @(negedge clk); b3.open_poll = 1'b0;
    chk("open3_state", 32'(b3.state), 1);
    b3.cand_sel = 2'd3;
    press(1, 10);
    chk("oor_rej3",    32'(rej3), 2);
    chk("oor_counts3", 32'(b3.vote_counts), 0);
    b3.cand_sel = 2'd2;
    press(1, 10);
    chk("cand2_ack3",    32'(ack3), 1);
    chk("cand2_counts3", 32'(b3.vote_counts), 32'h040);

    // poll 1: three clean presses on candidate 2
    pulse4(1);
    chk("open_state", 32'(b4.state), 1);
    b4.cand_sel = 2'd2;
    @(negedge clk); b4.vote_btn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (b4.vote_ack && lat == 0) lat = i;
    end
    b4.vote_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("ack_latency", 32'(lat), 7);
    press(0, 10);
    press(0, 10);
    chk("p1_counts", 32'(b4.vote_counts), 32'h0C0);
    chk("p1_total",  32'(b4.total_votes), 3);
    chk("p1_acks",   32'(ack4), 3);
    chk("p1_leader", 32'(b4.leader), 2);
    chk("p1_tie",    32'(b4.tie), 0);

    // bouncing press then long hold: one count each
    a0 = ack4;
    @(negedge clk);
    b4.vote_btn = 1; repeat (2) @(negedge clk);
    b4.vote_btn = 0; repeat (2) @(negedge clk);
    b4.vote_btn = 1; repeat (2) @(negedge clk);
    b4.vote_btn = 0; repeat (2) @(negedge clk);
    b4.vote_btn = 1; repeat (10) @(negedge clk);
    b4.vote_btn = 0; repeat (12) @(negedge clk);
    chk("bounce_acks",   32'(ack4 - a0), 1);
    chk("bounce_counts", 32'(b4.vote_counts), 32'h100);
    press(0, 50);
    chk("hold_acks",   32'(ack4 - a0), 2);
    chk("hold_counts", 32'(b4.vote_counts), 32'h140);
    chk("p1_no_rej",   32'(rej4), 0);

    // poll 2: saturation of candidate 0 and of total_votes
    pulse4(0);
    chk("close_state", 32'(b4.state), 2);
    chk("close_rv",    32'(b4.result_valid), 1);
    pulse4(1);
    chk("reopen_state",  32'(b4.state), 1);
    chk("reopen_counts", 32'(b4.vote_counts), 0);
    chk("reopen_total",  32'(b4.total_votes), 0);
    b4.cand_sel = 2'd0;
    a0 = ack4; r0 = rej4;
    repeat (9) press(0, 10);
    chk("sat_acks",   32'(ack4 - a0), 7);
    chk("sat_rejs",   32'(rej4 - r0), 2);
    chk("sat_counts", 32'(b4.vote_counts), 32'h007);
    chk("sat_total",  32'(b4.total_votes), 7);
    b4.cand_sel = 2'd1;
    press(0, 10);
    chk("tsat_acks",   32'(ack4 - a0), 8);
    chk("tsat_counts", 32'(b4.vote_counts), 32'h00F);
    chk("tsat_total",  32'(b4.total_votes), 7);

    // poll 3: tie between 1 and 3, vote coinciding with close_poll
    pulse4(0);
    pulse4(1);
    press(0, 10); press(0, 10);
    b4.cand_sel = 2'd3;
    press(0, 10); press(0, 10);
    chk("p3_counts", 32'(b4.vote_counts), 32'h410);
    chk("p3_total",  32'(b4.total_votes), 4);
    a0 = ack4; r0 = rej4;
    b4.cand_sel = 2'd0;
    @(negedge clk); b4.vote_btn = 1'b1;
    repeat (6) @(negedge clk);
    b4.close_poll = 1'b1;
    @(negedge clk); b4.close_poll = 1'b0;
    repeat (4) @(negedge clk);
    b4.vote_btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("cc_rej",    32'(rej4 - r0), 1);
    chk("cc_ack",    32'(ack4 - a0), 0);
    chk("cc_state",  32'(b4.state), 2);
    chk("cc_rv",     32'(b4.result_valid), 1);
    chk("cc_counts", 32'(b4.vote_counts), 32'h410);
    chk("cc_leader", 32'(b4.leader), 1);
    chk("cc_tie",    32'(b4.tie), 1);
    press(0, 10);
    chk("closed_rej",    32'(rej4 - r0), 2);
    chk("closed_counts", 32'(b4.vote_counts), 32'h410);

    // asynchronous reset mid-poll
    pulse4(1);
    b4.cand_sel = 2'd3;
    press(0, 10);
    chk("pre_rst_counts", 32'(b4.vote_counts), 32'h200);
    chk("pre_rst_leader", 32'(b4.leader), 3);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("arst_state",  32'(b4.state), 0);
    chk("arst_counts", 32'(b4.vote_counts), 0);
    chk("arst_total",  32'(b4.total_votes), 0);
    chk("arst_leader", 32'(b4.leader), 0);
    b4.vote_btn = 1'b1;
    a0 = ack4; r0 = rej4;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    pulse4(1);
    repeat (20) @(negedge clk);
    chk("held_ack", 32'(ack4 - a0), 0);
    chk("held_rej", 32'(rej4 - r0), 0);
    b4.vote_btn = 1'b0;
    repeat (12) @(negedge clk);
    press(0, 10);
    chk("post_held_ack", 32'(ack4 - a0), 1);
    pulse4(0);
    chk("fin_closed_counts", 32'(b4.vote_counts), 32'h200);
    pulse4(1);
    chk("fin_open_state",  32'(b4.state), 1);
    chk("fin_open_counts", 32'(b4.vote_counts), 0);
    chk("ack_rej_excl", 32'(both), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
